// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 width codes,
// FSM state encoding and the byte-lane mask helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      RESP,
      ERR
   } state_e;

   // Bits of the 32-bit word touched by an access of this width at byte offset off.
   function automatic logic [31:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         2'b00:   lane_mask = 32'h0000_00FF << {off, 3'b000};
         2'b01:   lane_mask = 32'h0000_FFFF << {off[1], 4'b0000};
         default: lane_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// CPU request/response and RAM bus of the load/store unit.
// slave = the LSU itself; master = the CPU/RAM environment around it.
interface lsu_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: merges store data into a RAM word and extracts
// plus sign/zero-extends load data. Shared with the future cache path.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] st_word,
   output logic [31:0] ld_data
);

   logic [4:0]  sh;
   logic [31:0] mask;
   logic [31:0] lane;

   always_comb begin
      sh      = (funct3[1:0] == 2'b01) ? {off[1], 4'b0000} : {off, 3'b000};
      mask    = lane_mask(funct3, off);
      st_word = (word & ~mask) | ((wdata << sh) & mask);
      lane    = word >> sh;
      case (funct3)
         F3_B:    ld_data = {{24{lane[7]}}, lane[7:0]};
         F3_H:    ld_data = {{16{lane[15]}}, lane[15:0]};
         F3_BU:   ld_data = {24'h0, lane[7:0]};
         F3_HU:   ld_data = {16'h0, lane[15:0]};
         default: ld_data = word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between CPU execute stage and word-only data RAM.
// Optional: define LSU_PERF_CNT_EN to add perf_loads/perf_stores counters.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 256
)
(
   input  logic           clk,
   input  logic           rst,
   lsu_mem_ctrl_if.slave  bus
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [31:0]    perf_loads,
   output logic [31:0]    perf_stores
`endif
);

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

   state_e      state, state_nx;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, word_q;
   logic        accept, fault_nx;
   logic [31:0] st_word, ld_data;

   assign accept = bus.req_valid && bus.req_ready;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      fault_nx = 1'b0;
      case (bus.req_funct3)
         F3_B, F3_BU: fault_nx = 1'b0;
         F3_H, F3_HU: fault_nx = bus.req_addr[0];
         F3_W:        fault_nx = |bus.req_addr[1:0];
         default:     fault_nx = 1'b1;
      endcase
      if (bus.req_we && (bus.req_funct3 == F3_BU || bus.req_funct3 == F3_HU))
         fault_nx = 1'b1;
      if ({1'b0, bus.req_addr} >= ADDR_LIMIT)
         fault_nx = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept)
                  state_nx = fault_nx ? ERR :
                             (bus.req_we && bus.req_funct3 == F3_W) ? WR : RD;
         RD:      state_nx = we_q ? WR : RESP;
         WR:      state_nx = RESP;
         RESP:    state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         word_q  <= 32'h0;
      end else begin
         if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (state == RD)
            word_q <= bus.mem_rdata;
      end
   end

   lsu_lane_align u_align (
      .funct3  (f3_q),
      .off     (addr_q[1:0]),
      .word    (word_q),
      .wdata   (wdata_q),
      .st_word (st_word),
      .ld_data (ld_data)
   );

   // mem_addr stays on the same word through RD and WR so the merge and write agree.
   always_comb begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_fault = 1'b0;
      bus.rsp_rdata = 32'h0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      case (state)
         IDLE: bus.req_ready = 1'b1;
         RD:   bus.mem_addr  = {addr_q[31:2], 2'b00};
         WR: begin
            bus.mem_we    = !rst;
            bus.mem_addr  = {addr_q[31:2], 2'b00};
            bus.mem_wdata = st_word;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = we_q ? 32'h0 : ld_data;
         end
         ERR: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_fault = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef LSU_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_loads  <= 32'h0;
         perf_stores <= 32'h0;
      end else if (state_nx == RESP && state != RESP) begin
         if (we_q) perf_stores <= perf_stores + 32'd1;
         else      perf_loads  <= perf_loads + 32'd1;
      end
   end
`endif

endmodule
